// File: rtl/mtdir_if.sv
// Console/controller bus bundle for the magtape DIR engine.
// slave  : the mtdir responder (consumes console strobes and read words,
//          drives DIR readback, write-FIFO head and read-FIFO ready).
// master : the console/controller side driving the responder.
// Bit orderings: wrDATA/rdDATA are [0:35] (element 0 is KS10 bit 0, the MSB).
interface mtdir_if;
  logic        mtWRLO;
  logic        mtWRHI;
  logic [3:0]  mtWSTRB;
  logic [31:0] mtDATAI;
  logic [63:0] mtDIRO;
  logic        wrVALID;
  logic [0:35] wrDATA;
  logic        wrREADY;
  logic        rdVALID;
  logic [0:35] rdDATA;
  logic        rdREADY;

  modport slave (
    input  mtWRLO, mtWRHI, mtWSTRB, mtDATAI, wrREADY, rdVALID, rdDATA,
    output mtDIRO, wrVALID, wrDATA, rdREADY
  );

  modport master (
    output mtWRLO, mtWRHI, mtWSTRB, mtDATAI, wrREADY, rdVALID, rdDATA,
    input  mtDIRO, wrVALID, wrDATA, rdREADY
  );
endinterface

// File: rtl/mtdir.sv
// mtdir: magtape-side Data Interface Register engine.
// Console half-word writes build a 36-bit staging word; a GO control bit
// commits it to the write FIFO for the tape controller. Controller read
// words queue in the read FIFO and are shown on mtDIRO with status bits.
// Ports: clk, rstn (async active-low), bus (mtdir_if.slave).
// Parameter DEPTH: entries per FIFO, 2 or 4.
// Optional feature macro MTDIR_LOOPBACK_EN: committed words go straight into
// the read FIFO; rdVALID/rdDATA/wrREADY are ignored and wrVALID stays 0.
module mtdir #(
  parameter int unsigned DEPTH = 4
) (
  input logic   clk,
  input logic   rstn,
  mtdir_if.slave bus
);

  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [35:0]   stage, stageNext;
  logic          ovf, ovfNext;

  logic [35:0]   wMem [DEPTH];
  logic [PW-1:0] wRd, wWr;
  logic [CW-1:0] wCnt;
  logic [35:0]   rMem [DEPTH];
  logic [PW-1:0] rRd, rWr;
  logic [CW-1:0] rCnt;

  logic ctl, go, ack, ovfClr;
  logic wFull, wEmpty, rFull, rEmpty;
  logic wPush, wPop, rPush, rPop, drop;
  logic [35:0] rPushData;

  logic          wrValidC;
  logic          fullRepC;
  logic [CW-1:0] cntRepC;

  // Staging word with byte-lane merge; GO sees the merged value.
  always_comb begin
    stageNext = stage;
    if (bus.mtWRLO) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.mtWSTRB[n]) stageNext[8*n +: 8] = bus.mtDATAI[8*n +: 8];
      end
    end
    if (bus.mtWRHI && bus.mtWSTRB[0]) stageNext[35:32] = bus.mtDATAI[3:0];
  end

  // High-half control bits.
  assign ctl    = bus.mtWRHI && bus.mtWSTRB[3];
  assign go     = ctl && bus.mtDATAI[31];
  assign ack    = ctl && bus.mtDATAI[30];
  assign ovfClr = ctl && bus.mtDATAI[29];

  assign wFull  = (wCnt == FULL_CNT);
  assign wEmpty = (wCnt == '0);
  assign rFull  = (rCnt == FULL_CNT);
  assign rEmpty = (rCnt == '0);

  // FIFO push/pop decisions; a pop in the same cycle frees a full slot.
  always_comb begin
    wPush     = 1'b0;
    wPop      = 1'b0;
    rPush     = 1'b0;
    rPop      = ack && !rEmpty;
    drop      = 1'b0;
    rPushData = stageNext;
`ifdef MTDIR_LOOPBACK_EN
    rPush     = go && (!rFull || rPop);
    drop      = go && rFull && !rPop;
`else
    wPop      = !wEmpty && bus.wrREADY;
    wPush     = go && (!wFull || wPop);
    drop      = go && wFull && !wPop;
    rPush     = bus.rdVALID && !rFull;
    rPushData = bus.rdDATA;
`endif
  end

  // A dropping GO wins over a simultaneous OVFCLR.
  always_comb begin
    ovfNext = ovf;
    if (ovfClr) ovfNext = 1'b0;
    if (drop)   ovfNext = 1'b1;
  end

  function automatic logic [CW-1:0] nextCnt(input logic [CW-1:0] cnt,
                                            input logic push, input logic pop);
    logic [CW-1:0] res;
    res = cnt;
    if (push && !pop) res = cnt + CW'(1);
    if (!push && pop) res = cnt - CW'(1);
    return res;
  endfunction

  // Control state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage <= '0;
      ovf   <= 1'b0;
      wRd   <= '0;
      wWr   <= '0;
      wCnt  <= '0;
      rRd   <= '0;
      rWr   <= '0;
      rCnt  <= '0;
    end else begin
      stage <= stageNext;
      ovf   <= ovfNext;
      if (wPush) wWr <= wWr + PW'(1);
      if (wPop)  wRd <= wRd + PW'(1);
      wCnt  <= nextCnt(wCnt, wPush, wPop);
      if (rPush) rWr <= rWr + PW'(1);
      if (rPop)  rRd <= rRd + PW'(1);
      rCnt  <= nextCnt(rCnt, rPush, rPop);
    end
  end

  // FIFO storage; contents are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (wPush) wMem[wWr] <= stageNext;
    if (rPush) rMem[rWr] <= rPushData;
  end

`ifdef MTDIR_LOOPBACK_EN
  logic unusedLoopInputs;
  assign unusedLoopInputs = ^{bus.wrREADY, bus.rdVALID, bus.rdDATA};
  assign wrValidC = 1'b0;
  assign fullRepC = rFull;
  assign cntRepC  = rCnt;
`else
  assign wrValidC = !wEmpty;
  assign fullRepC = wFull;
  assign cntRepC  = wCnt;
`endif

  assign bus.wrVALID = wrValidC;
  assign bus.wrDATA  = wrValidC ? wMem[wRd] : 36'b0;
  assign bus.rdREADY = !rFull;
  assign bus.mtDIRO  = {fullRepC, !rEmpty, ovf, 2'b00, cntRepC, 20'b0,
                        rEmpty ? 36'b0 : rMem[rRd]};

endmodule

// File: tb/tb_mtdir.sv
// Directed bench for mtdir: vector table for the basic write path plus
// hand sequences for overflow, concurrency, read path and reset.
module tb_mtdir;

  logic clk;
  logic rstn;
  int   nCmp;
  int   nFail;

  mtdir_if bus();

  mtdir #(.DEPTH(4)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lo;
    logic        hi;
    logic [3:0]  strb;
    logic [31:0] data;
    logic        wrRdy;
    logic        rdV;
    logic [35:0] rdD;
    logic        eWrV;
    logic [35:0] eWrD;
    logic [63:0] eDiro;
    logic        eRdRdy;
  } vec_t;

  vec_t tbl [9];

  // Expected DIR readback from status fields.
  function automatic logic [63:0] mk(input logic wf, input logic rdv,
                                     input logic ov, input logic [2:0] cnt,
                                     input logic [35:0] head);
    return {wf, rdv, ov, 2'b00, cnt, 20'b0, head};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkAll(input string nm, input logic eWrV, input logic [35:0] eWrD,
                        input logic [63:0] eDiro, input logic eRdRdy);
    chk({nm, ".wrVALID"}, 64'(bus.wrVALID), 64'(eWrV));
    chk({nm, ".wrDATA"},  64'(bus.wrDATA),  64'(eWrD));
    chk({nm, ".mtDIRO"},  bus.mtDIRO,       eDiro);
    chk({nm, ".rdREADY"}, 64'(bus.rdREADY), 64'(eRdRdy));
  endtask

  task automatic idle();
    bus.mtWRLO  = 1'b0;
    bus.mtWRHI  = 1'b0;
    bus.mtWSTRB = 4'h0;
    bus.mtDATAI = 32'h0;
    bus.wrREADY = 1'b0;
    bus.rdVALID = 1'b0;
    bus.rdDATA  = 36'h0;
  endtask

  // One clock with the given inputs, then inputs return to idle.
  task automatic cyc(input logic lo, input logic hi, input logic [3:0] s,
                     input logic [31:0] d, input logic wr, input logic rv,
                     input logic [35:0] rd);
    bus.mtWRLO  = lo;
    bus.mtWRHI  = hi;
    bus.mtWSTRB = s;
    bus.mtDATAI = d;
    bus.wrREADY = wr;
    bus.rdVALID = rv;
    bus.rdDATA  = rd;
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    nCmp  = 0;
    nFail = 0;
    idle();
    rstn = 1'b0;
    #1;
    chkAll("reset0", 1'b0, 36'h0, 64'h0, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

`ifdef MTDIR_LOOPBACK_EN
    cyc(1, 0, 4'hF, 32'h00000055, 0, 0, 36'h0);
    cyc(0, 1, 4'h9, 32'h80000000, 0, 0, 36'h0);
    chkAll("lb.go", 1'b0, 36'h0, mk(0, 1, 0, 3'd1, 36'h055), 1'b1);
    cyc(0, 0, 4'h0, 32'h0, 1, 1, 36'h999999999);
    chkAll("lb.rdIgnored", 1'b0, 36'h0, mk(0, 1, 0, 3'd1, 36'h055), 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 4'h8, 32'h80000000, 0, 0, 36'h0);
    chkAll("lb.full", 1'b0, 36'h0, mk(1, 1, 0, 3'd4, 36'h055), 1'b0);
    cyc(0, 1, 4'h8, 32'h80000000, 0, 0, 36'h0);
    chkAll("lb.drop", 1'b0, 36'h0, mk(1, 1, 1, 3'd4, 36'h055), 1'b0);
`else
    // Write path vectors: inputs for one cycle, outputs after the edge.
    tbl[0] = '{0, 0, 4'h0, 32'h00000000, 0, 0, 36'h0, 0, 36'h0,         64'h0, 1};
    tbl[1] = '{1, 0, 4'hF, 32'h89ABCDEF, 0, 0, 36'h0, 0, 36'h0,         64'h0, 1};
    tbl[2] = '{0, 1, 4'h9, 32'h80000007, 0, 0, 36'h0, 1, 36'h789ABCDEF, mk(0, 0, 0, 3'd1, 36'h0), 1};
    tbl[3] = '{0, 0, 4'h0, 32'h00000000, 1, 0, 36'h0, 0, 36'h0,         64'h0, 1};
    tbl[4] = '{1, 0, 4'h5, 32'h11223344, 0, 0, 36'h0, 0, 36'h0,         64'h0, 1};
    tbl[5] = '{0, 1, 4'h8, 32'h8000000A, 0, 0, 36'h0, 1, 36'h78922CD44, mk(0, 0, 0, 3'd1, 36'h0), 1};
    tbl[6] = '{1, 1, 4'h9, 32'h800000FF, 0, 0, 36'h0, 1, 36'h78922CD44, mk(0, 0, 0, 3'd2, 36'h0), 1};
    tbl[7] = '{0, 0, 4'h0, 32'h00000000, 1, 0, 36'h0, 1, 36'hF8022CDFF, mk(0, 0, 0, 3'd1, 36'h0), 1};
    tbl[8] = '{0, 0, 4'h0, 32'h00000000, 1, 0, 36'h0, 0, 36'h0,         64'h0, 1};
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].lo, tbl[i].hi, tbl[i].strb, tbl[i].data, tbl[i].wrRdy,
          tbl[i].rdV, tbl[i].rdD);
      chkAll($sformatf("v%0d", i), tbl[i].eWrV, tbl[i].eWrD, tbl[i].eDiro, tbl[i].eRdRdy);
    end

    // Overflow: back-to-back GOs with the controller stalled.
    cyc(1, 0, 4'hF, 32'h00000055, 0, 0, 36'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 1, 4'h8, 32'h80000000, 0, 0, 36'h0);
      chkAll($sformatf("ovf.go%0d", k), 1'b1, 36'hF00000055,
             mk(k >= 4, 0, k == 5, (k >= 4) ? 3'd4 : 3'(k), 36'h0), 1'b1);
    end
    cyc(0, 1, 4'h8, 32'h20000000, 0, 0, 36'h0);
    chk("ovf.clr", bus.mtDIRO, mk(1, 0, 0, 3'd4, 36'h0));

    // Commit and pop together on a full FIFO is accepted.
    cyc(1, 0, 4'hF, 32'h00000066, 0, 0, 36'h0);
    cyc(0, 1, 4'h8, 32'h80000000, 1, 0, 36'h0);
    chkAll("conc.goPop", 1'b1, 36'hF00000055, mk(1, 0, 0, 3'd4, 36'h0), 1'b1);
    cyc(0, 1, 4'h8, 32'hA0000000, 0, 0, 36'h0);
    chk("ovf.clrAndDrop", bus.mtDIRO, mk(1, 0, 1, 3'd4, 36'h0));
    cyc(0, 1, 4'h8, 32'h20000000, 0, 0, 36'h0);
    cyc(0, 0, 4'h0, 32'h0, 1, 0, 36'h0);
    chkAll("drain1", 1'b1, 36'hF00000055, mk(0, 0, 0, 3'd3, 36'h0), 1'b1);
    cyc(0, 0, 4'h0, 32'h0, 1, 0, 36'h0);
    cyc(0, 0, 4'h0, 32'h0, 1, 0, 36'h0);
    chkAll("drain3", 1'b1, 36'hF00000066, mk(0, 0, 0, 3'd1, 36'h0), 1'b1);
    cyc(0, 0, 4'h0, 32'h0, 1, 0, 36'h0);
    chkAll("drain4", 1'b0, 36'h0, 64'h0, 1'b1);

    // Read path.
    cyc(0, 0, 4'h0, 32'h0, 0, 1, 36'h123456789);
    chk("rd.push1", bus.mtDIRO, mk(0, 1, 0, 3'd0, 36'h123456789));
    cyc(0, 0, 4'h0, 32'h0, 0, 1, 36'hFEDCBA987);
    chk("rd.push2", bus.mtDIRO, mk(0, 1, 0, 3'd0, 36'h123456789));
    cyc(0, 1, 4'h8, 32'h40000000, 0, 0, 36'h0);
    chk("rd.ack1", bus.mtDIRO, mk(0, 1, 0, 3'd0, 36'hFEDCBA987));
    cyc(0, 1, 4'h8, 32'h40000000, 0, 1, 36'h111111111);
    chk("rd.pushAck", bus.mtDIRO, mk(0, 1, 0, 3'd0, 36'h111111111));
    cyc(0, 1, 4'h8, 32'h40000000, 0, 0, 36'h0);
    chk("rd.ackLast", bus.mtDIRO, 64'h0);
    cyc(0, 1, 4'h8, 32'h40000000, 0, 0, 36'h0);
    chkAll("rd.ackEmpty", 1'b0, 36'h0, 64'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 4'h0, 32'h0, 0, 1, 36'hA00000000 + 36'(i));
      chk($sformatf("rd.fill%0d.rdREADY", i), 64'(bus.rdREADY), 64'(i < 3));
    end
    cyc(0, 0, 4'h0, 32'h0, 0, 1, 36'hBBBBBBBBB);
    chk("rd.fullPush", bus.mtDIRO, mk(0, 1, 0, 3'd0, 36'hA00000000));
    for (int i = 1; i < 4; i++) begin
      cyc(0, 1, 4'h8, 32'h40000000, 0, 0, 36'h0);
      chk($sformatf("rd.drain%0d", i), bus.mtDIRO, mk(0, 1, 0, 3'd0, 36'hA00000000 + 36'(i)));
    end
    cyc(0, 1, 4'h8, 32'h40000000, 0, 0, 36'h0);
    chk("rd.drainEnd", bus.mtDIRO, 64'h0);

    // Reset mid-operation with two queued words and a read word.
    cyc(1, 0, 4'hF, 32'h00000011, 0, 0, 36'h0);
    cyc(0, 1, 4'h8, 32'h80000000, 0, 1, 36'h000000005);
    cyc(0, 1, 4'h8, 32'h80000000, 0, 0, 36'h0);
    chkAll("preRst", 1'b1, 36'hF00000011, mk(0, 1, 0, 3'd2, 36'h5), 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chkAll("midRst", 1'b0, 36'h0, 64'h0, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    cyc(0, 0, 4'h0, 32'h0, 1, 0, 36'h0);
    chkAll("postRst", 1'b0, 36'h0, 64'h0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
